// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register-busy scoreboard for the in-order issue stage
// Tracks in-flight destination registers, detects RAW/WAW hazards and flags stray writebacks.
module reg_scoreboard #(
    parameter int NREG   = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              issue_wen,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] issue_rs1,
    input  logic [ADDR_W-1:0] issue_rs2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              flush,
    output logic              stall,
    output logic              issue_fire,
    output logic [NREG-1:0]   busy_vec,
    output logic [CNT_W-1:0]  busy_cnt,
    output logic              wb_err
);

    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

    // Indices beyond the register file decode to nothing, so they never hit a busy bit.
    function automatic logic [NREG-1:0] dec(input logic [ADDR_W-1:0] idx);
        if (int'(idx) < NREG) dec = ONE << idx;
        else                  dec = '0;
    endfunction

    logic [NREG-1:0]  r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wb_err;

    logic [NREG-1:0]  w_clr;
    logic [NREG-1:0]  w_eff;
    logic [NREG-1:0]  w_set;
    logic [NREG-1:0]  w_next;
    logic [CNT_W-1:0] w_cnt;
    logic             w_haz;
    logic             w_fire;
    logic             w_wb_bad;

    always_comb begin
        w_clr  = wb_valid ? dec(wb_rd) : '0;
        w_eff  = r_busy & ~w_clr;
        w_haz  = (|(w_eff & dec(issue_rs1)))
               | (|(w_eff & dec(issue_rs2)))
               | (issue_wen & (|(w_eff & dec(issue_rd))));
        w_fire = issue_valid & ~w_haz;
        w_set  = (w_fire && issue_wen && issue_rd != '0) ? dec(issue_rd) : '0;
        // Set is OR'd after the clear so a new producer keeps ownership of the register.
        w_next = ((r_busy & ~w_clr) | w_set) & ~ONE;
        w_cnt  = '0;
        for (int i = 0; i < NREG; i++) begin
            w_cnt = w_cnt + CNT_W'(w_next[i]);
        end
        w_wb_bad = wb_valid & (((wb_rd != '0) & ~(|(r_busy & dec(wb_rd))))
                             | (int'(wb_rd) >= NREG));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy   <= '0;
            r_cnt    <= '0;
            r_wb_err <= 1'b0;
        end else begin
            if (flush) begin
                r_busy <= '0;
                r_cnt  <= '0;
            end else begin
                r_busy <= w_next;
                r_cnt  <= w_cnt;
            end
            if (w_wb_bad) r_wb_err <= 1'b1;
        end
    end

    assign stall      = issue_valid & w_haz;
    assign issue_fire = w_fire;
    assign busy_vec   = r_busy;
    assign busy_cnt   = r_cnt;
    assign wb_err     = r_wb_err;

endmodule
